// File: rtl/spi_slave_std_pkg.sv
// Shared types and defaults for the standard SPI responder.
package spi_slave_std_pkg;

    // Frame state of the responder
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StSkip   = 2'd2
    } state_e;

    localparam int unsigned RxBitsDefault   = 48;
    localparam int unsigned TxBitsDefault   = 80;
    localparam logic        IdleFillDefault = 1'b1;

    // Bit counter width; the counter saturates at its maximum value
    localparam int unsigned CntWidth = 8;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser for an SPI pin plus rise/fall strobe generation.
module spi_pin_sync #(
    parameter logic ResetVal = 1'b1
) (
    input  logic spi_clk_i,
    input  logic spi_rst_i,
    input  logic pin_i,
    output logic rise_o,
    output logic fall_o
);

    // [0] first sync stage, [1] synchronised level, [2] delayed copy for edge detection
    logic [2:0] pin_q;

    // Shift the pin through the synchroniser and delay stage
    always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
        if (!spi_rst_i) begin
            pin_q <= {3{ResetVal}};
        end else begin
            pin_q <= {pin_q[1:0], pin_i};
        end
    end

    // One-cycle strobes on each synchronised transition
    always_comb begin
        rise_o = pin_q[1] & ~pin_q[2];
        fall_o = ~pin_q[1] & pin_q[2];
    end

endmodule

// File: rtl/spi_slave_std.sv
// SPI responder: receives RX_BITS on MOSI, returns TX_BITS on MISO, pins oversampled
// in the spi_clk_i domain.
module spi_slave_std
    import spi_slave_std_pkg::*;
#(
    parameter int unsigned RX_BITS   = RxBitsDefault,
    parameter int unsigned TX_BITS   = TxBitsDefault,
    parameter logic        IDLE_FILL = IdleFillDefault
) (
    input  logic               spi_clk_i,
    input  logic               spi_rst_i,
    input  logic               spi_fbo_i,
    input  logic               SCK,
    input  logic               SS,
    input  logic               MOSI,
    output logic               MISO,
    output logic               miso_oe_o,
    input  logic [TX_BITS-1:0] tx_data_i,
    input  logic               tx_valid_i,
    output logic               tx_ack_o,
    output logic [RX_BITS-1:0] rx_data_o,
    output logic               rx_valid_o,
    output logic               frame_err_o,
    output logic               busy_o
);

    localparam logic [CntWidth-1:0] RxLast = CntWidth'(RX_BITS - 1);
    localparam logic [CntWidth-1:0] RxCnt  = CntWidth'(RX_BITS);
    localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};

    logic sck_rise, sck_fall;
    logic ss_rise, ss_fall;
    logic [1:0] mosi_q;

    state_e               state_q;
    logic                 fbo_q;
    logic [CntWidth-1:0]  cnt_q;
    logic [RX_BITS-1:0]   rx_shift_q;
    logic [TX_BITS-1:0]   tx_shift_q;
    logic [RX_BITS-1:0]   rx_data_q;
    logic                 rx_pend_q;
    logic                 rx_valid_q;
    logic                 tx_ack_q;
    logic                 frame_err_q;
    logic                 busy_q;
    logic                 miso_q;
    logic                 miso_oe_q;

    logic [TX_BITS-1:0]   tx_load;
    logic                 tx_load_bit;
    logic [TX_BITS-1:0]   tx_next;
    logic                 tx_next_bit;
    logic [RX_BITS-1:0]   rx_next;
    logic [CntWidth-1:0]  cnt_inc;

    // SCK idles high, so its synchroniser resets high to avoid a spurious edge
    spi_pin_sync #(
        .ResetVal (1'b1)
    ) u_sck_sync (
        .spi_clk_i (spi_clk_i),
        .spi_rst_i (spi_rst_i),
        .pin_i     (SCK),
        .rise_o    (sck_rise),
        .fall_o    (sck_fall)
    );

    // SS resets to "selected": the FSM starts in SKIP and only leaves it on a seen
    // SS rise, so a reset while SS is low can never join a frame mid-way
    spi_pin_sync #(
        .ResetVal (1'b0)
    ) u_ss_sync (
        .spi_clk_i (spi_clk_i),
        .spi_rst_i (spi_rst_i),
        .pin_i     (SS),
        .rise_o    (ss_rise),
        .fall_o    (ss_fall)
    );

    // MOSI synchroniser, same depth as the SCK path so data lines up with the strobe
    always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
        if (!spi_rst_i) begin
            mosi_q <= 2'b11;
        end else begin
            mosi_q <= {mosi_q[0], MOSI};
        end
    end

    // Next values for load, shift and count
    always_comb begin
        tx_load     = tx_valid_i ? tx_data_i : {TX_BITS{IDLE_FILL}};
        tx_load_bit = spi_fbo_i ? tx_load[TX_BITS-1] : tx_load[0];
        tx_next     = fbo_q ? {tx_shift_q[TX_BITS-2:0], IDLE_FILL}
                            : {IDLE_FILL, tx_shift_q[TX_BITS-1:1]};
        tx_next_bit = fbo_q ? tx_shift_q[TX_BITS-2] : tx_shift_q[1];
        rx_next     = fbo_q ? {rx_shift_q[RX_BITS-2:0], mosi_q[1]}
                            : {mosi_q[1], rx_shift_q[RX_BITS-1:1]};
        cnt_inc     = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    end

    // Frame FSM with registered outputs
    always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
        if (!spi_rst_i) begin
            state_q     <= StSkip;
            fbo_q       <= 1'b1;
            cnt_q       <= '0;
            rx_shift_q  <= '1;
            tx_shift_q  <= '1;
            rx_data_q   <= '0;
            rx_pend_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_ack_q    <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            miso_q      <= IDLE_FILL;
            miso_oe_q   <= 1'b0;
        end else begin
            tx_ack_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_pend_q   <= 1'b0;

            // Report the word one cycle after the RX_BITS-th bit was shifted in
            if (rx_pend_q) begin
                rx_data_q  <= rx_shift_q;
                rx_valid_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (ss_fall) begin
                        fbo_q      <= spi_fbo_i;
                        cnt_q      <= '0;
                        rx_shift_q <= '0;
                        tx_shift_q <= tx_load;
                        tx_ack_q   <= tx_valid_i;
                        miso_q     <= tx_load_bit;
                        miso_oe_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= StActive;
                    end
                end
                StActive: begin
                    // SS release takes priority over a coincident SCK edge
                    if (ss_rise) begin
                        frame_err_q <= (cnt_q < RxCnt);
                        miso_q      <= IDLE_FILL;
                        miso_oe_q   <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end else if (sck_rise) begin
                        rx_shift_q <= rx_next;
                        cnt_q      <= cnt_inc;
                        if (cnt_q == RxLast) begin
                            rx_pend_q <= 1'b1;
                        end
                    end else if (sck_fall && (cnt_q != '0)) begin
                        // The falling edge before the first bit is setup only
                        tx_shift_q <= tx_next;
                        miso_q     <= tx_next_bit;
                    end
                end
                StSkip: begin
                    if (ss_rise) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Output drive from registers
    always_comb begin
        MISO        = miso_q;
        miso_oe_o   = miso_oe_q;
        tx_ack_o    = tx_ack_q;
        rx_data_o   = rx_data_q;
        rx_valid_o  = rx_valid_q;
        frame_err_o = frame_err_q;
        busy_o      = busy_q;
    end

endmodule
